// File: rtl/mesh_term_pkg.sv
// Shared packet layout and helpers for the mesh terminal bank.
// Field offsets are measured from the top of the payload, so one layout works for any packet width.
// Layout, MSB first: Nxt_jump, id_row, id_colum, mode, payload.
package mesh_term_pkg;

  localparam int NXT_W  = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int MODE_W = 1;
  localparam int HDR_W  = NXT_W + ROW_W + COL_W + MODE_W;

  // Field offsets above the payload.
  localparam int MODE_OFF = 0;
  localparam int COL_OFF  = MODE_OFF + MODE_W;
  localparam int ROW_OFF  = COL_OFF + COL_W;
  localparam int NXT_OFF  = ROW_OFF + ROW_W;

  // Helpers work on a wide container; callers zero-extend in and truncate out.
  localparam int PKT_MAX_W = 128;

  // Build a packet with Nxt_jump forced to zero; payload must fit in pl_w bits.
  function automatic logic [PKT_MAX_W-1:0] mk_pkt(
    input logic [ROW_W-1:0]     row,
    input logic [COL_W-1:0]     col,
    input logic                 mode,
    input logic [PKT_MAX_W-1:0] payload,
    input int                   pl_w
  );
    logic [PKT_MAX_W-1:0] hdr;
    hdr = '0;
    hdr[NXT_OFF +: NXT_W]   = '0;
    hdr[ROW_OFF +: ROW_W]   = row;
    hdr[COL_OFF +: COL_W]   = col;
    hdr[MODE_OFF +: MODE_W] = mode;
    return (hdr << pl_w) | payload;
  endfunction

  // True when the packet targets this terminal or is a broadcast.
  function automatic logic addr_match(
    input logic [PKT_MAX_W-1:0]   pkt,
    input logic [ROW_W-1:0]       own_row,
    input logic [COL_W-1:0]       own_col,
    input logic [ROW_W+COL_W-1:0] bdcst,
    input int                     pl_w
  );
    logic [ROW_W+COL_W-1:0] dst;
    dst = (ROW_W+COL_W)'(pkt >> (pl_w + COL_OFF));
    return (dst == bdcst) || (dst == {own_row, own_col});
  endfunction

endpackage

// File: rtl/term_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
// Latency: a push at edge n is visible on dout after edge n.
// Backpressure: a push is taken when not full, or when full with a same-cycle pop; a pop on empty is ignored.
module term_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_rd    = pop & ~w_empty;
  assign w_wr    = push & (~w_full | w_rd);

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_cnt;
  assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written only on an accepted push, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_bank.sv
// Per-terminal TX packet build + FIFO and RX address filter + FIFO for every mesh edge terminal.
// Latency: TX push and RX accept each become visible at the FIFO head one edge later.
// Backpressure: TX pushes on a full FIFO are dropped; RX pop to the mesh is withheld while the RX FIFO is full.
module mesh_term_bank
  import mesh_term_pkg::*;
#(
  parameter int          ROWS       = 2,
  parameter int          COLUMS     = 2,
  parameter int          pckg_sz    = 32,
  parameter int          fifo_depth = 4,
  parameter logic [7:0]  bdcst      = 8'hFF,
  localparam int         NTRMS      = 2*ROWS + 2*COLUMS,
  localparam int         PL_W       = pckg_sz - HDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NTRMS-1:0]         tx_push,
  input  logic [NTRMS*4-1:0]       tx_row,
  input  logic [NTRMS*4-1:0]       tx_col,
  input  logic [NTRMS-1:0]         tx_mode,
  input  logic [NTRMS*PL_W-1:0]    tx_payload,
  output logic [NTRMS-1:0]         tx_full,
  input  logic [NTRMS*4-1:0]       own_row,
  input  logic [NTRMS*4-1:0]       own_col,
  output logic [NTRMS*pckg_sz-1:0] data_out_i_in,
  output logic [NTRMS-1:0]         pndng_i_in,
  input  logic [NTRMS-1:0]         popin,
  input  logic [NTRMS*pckg_sz-1:0] data_out,
  input  logic [NTRMS-1:0]         pndng,
  output logic [NTRMS-1:0]         pop,
  input  logic [NTRMS-1:0]         rx_pop,
  output logic [NTRMS*pckg_sz-1:0] rx_data,
  output logic [NTRMS-1:0]         rx_valid,
  output logic [NTRMS*8-1:0]       err_cnt
);

  for (genvar k = 0; k < NTRMS; k++) begin : g_ch
    logic [PKT_MAX_W-1:0]          w_pl_ext;
    logic [PKT_MAX_W-1:0]          w_rx_ext;
    logic [pckg_sz-1:0]            w_tx_din;
    logic                          w_tx_empty;
    logic                          w_rx_full;
    logic                          w_rx_empty;
    logic                          w_match;
    logic [$clog2(fifo_depth):0]   w_tx_cnt;
    logic [$clog2(fifo_depth):0]   w_rx_cnt;
    logic                          w_cnt_unused;
    logic [7:0]                    r_err;

    // TX: assemble the outgoing packet from the transaction fields.
    assign w_pl_ext = PKT_MAX_W'(tx_payload[k*PL_W +: PL_W]);
    assign w_tx_din = pckg_sz'(mk_pkt(tx_row[k*4 +: 4], tx_col[k*4 +: 4],
                                      tx_mode[k], w_pl_ext, PL_W));

    term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push[k]),
      .din   (w_tx_din),
      .pop   (popin[k]),
      .dout  (data_out_i_in[k*pckg_sz +: pckg_sz]),
      .full  (tx_full[k]),
      .empty (w_tx_empty),
      .count (w_tx_cnt)
    );

    assign pndng_i_in[k] = ~w_tx_empty;

    // RX: take from the mesh whenever there is room; keep only packets addressed here.
    assign pop[k]   = pndng[k] & ~w_rx_full & ~reset;
    assign w_rx_ext = PKT_MAX_W'(data_out[k*pckg_sz +: pckg_sz]);
    assign w_match  = addr_match(w_rx_ext, own_row[k*4 +: 4], own_col[k*4 +: 4], bdcst, PL_W);

    term_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pop[k] & w_match),
      .din   (data_out[k*pckg_sz +: pckg_sz]),
      .pop   (rx_pop[k]),
      .dout  (rx_data[k*pckg_sz +: pckg_sz]),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .count (w_rx_cnt)
    );

    assign rx_valid[k] = ~w_rx_empty;

    // Occupancy counts are not needed here; full/empty carry the same information.
    assign w_cnt_unused = ^{w_tx_cnt, w_rx_cnt};

    // Count accepted packets that fail the address check, holding at 8'hFF.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_err <= '0;
      end else if (pop[k] && !w_match && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end

    assign err_cnt[k*8 +: 8] = r_err;
  end

endmodule

// File: tb/tb_mesh_term_bank.sv
// Scoreboard bench for mesh_term_bank: queue-based model of each channel,
// directed scenarios followed by randomized traffic on all channels.
module tb_mesh_term_bank;

  localparam int NT  = 8;
  localparam int PW  = 32;
  localparam int D   = 4;
  localparam int PLW = PW - 17;

  logic clk = 1'b0;
  logic reset;
  logic [NT-1:0]     tx_push, tx_mode, tx_full, pndng_i_in, popin, pndng, pop, rx_pop, rx_valid;
  logic [NT*4-1:0]   tx_row, tx_col, own_row, own_col;
  logic [NT*PLW-1:0] tx_payload;
  logic [NT*PW-1:0]  data_out_i_in, data_out, rx_data;
  logic [NT*8-1:0]   err_cnt;

  always #5 clk = ~clk;

  mesh_term_bank #(.ROWS(2), .COLUMS(2), .pckg_sz(PW), .fifo_depth(D), .bdcst(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_row(tx_row), .tx_col(tx_col), .tx_mode(tx_mode),
    .tx_payload(tx_payload), .tx_full(tx_full),
    .own_row(own_row), .own_col(own_col),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .data_out(data_out), .pndng(pndng), .pop(pop),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_valid(rx_valid), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: occupancy, expected FIFO contents, error counts.
  int tx_occ[NT];
  int rx_occ[NT];
  int err_m[NT];
  logic [PW-1:0] exp_tx[NT][$];
  logic [PW-1:0] exp_rx[NT][$];

  task automatic chk(input string nm, input int ch, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch%0d got=%h expected=%h", nm, ch, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] tx_pkt(input int k);
    return {8'h00, tx_row[k*4 +: 4], tx_col[k*4 +: 4], tx_mode[k], tx_payload[k*PLW +: PLW]};
  endfunction

  function automatic bit addressed_here(input int k);
    logic [PW-1:0] p;
    logic [7:0] dst;
    p = data_out[k*PW +: PW];
    dst = p[PLW+1 +: 8];
    return (dst == 8'hFF) || (dst == {own_row[k*4 +: 4], own_col[k*4 +: 4]});
  endfunction

  task automatic clr();
    tx_push = '0; popin = '0; pndng = '0; rx_pop = '0;
  endtask

  task automatic set_tx(input int k, input logic [3:0] r, input logic [3:0] c, input logic m, input logic [PLW-1:0] p);
    tx_push[k] = 1'b1;
    tx_row[k*4 +: 4] = r;
    tx_col[k*4 +: 4] = c;
    tx_mode[k] = m;
    tx_payload[k*PLW +: PLW] = p;
  endtask

  task automatic set_rx(input int k, input logic [3:0] r, input logic [3:0] c, input logic [PLW-1:0] p);
    logic [7:0] nj;
    logic md;
    nj = 8'($urandom);
    md = 1'($urandom);
    pndng[k] = 1'b1;
    data_out[k*PW +: PW] = {nj, r, c, md, p};
  endtask

  task automatic rnd_rx(input int k);
    int s;
    s = $urandom_range(0, 3);
    case (s)
      0:       set_rx(k, own_row[k*4 +: 4], own_col[k*4 +: 4], PLW'($urandom));
      1:       set_rx(k, 4'hF, 4'hF, PLW'($urandom));
      default: set_rx(k, 4'($urandom), 4'($urandom), PLW'($urandom));
    endcase
  endtask

  // One clock: check status against the model, advance the model by the driven inputs, step past the edge.
  task automatic tick();
    #1;
    for (int k = 0; k < NT; k++) begin
      bit acc, ptx, wtx, prx, good;
      acc = pndng[k] && (rx_occ[k] < D) && !reset;
      chk("pndng_i_in", k, PW'(pndng_i_in[k]), PW'(tx_occ[k] > 0));
      chk("tx_full",    k, PW'(tx_full[k]),    PW'(tx_occ[k] == D));
      chk("rx_valid",   k, PW'(rx_valid[k]),   PW'(rx_occ[k] > 0));
      chk("err_cnt",    k, PW'(err_cnt[k*8 +: 8]), PW'(err_m[k]));
      chk("pop",        k, PW'(pop[k]),        PW'(acc));
      if (reset) begin
        tx_occ[k] = 0; rx_occ[k] = 0; err_m[k] = 0;
        exp_tx[k].delete(); exp_rx[k].delete();
      end else begin
        ptx = popin[k] && (tx_occ[k] > 0);
        wtx = tx_push[k] && ((tx_occ[k] < D) || popin[k]);
        if (wtx) exp_tx[k].push_back(tx_pkt(k));
        tx_occ[k] = tx_occ[k] + int'(wtx) - int'(ptx);
        prx = rx_pop[k] && (rx_occ[k] > 0);
        good = addressed_here(k);
        if (acc && good) begin
          exp_rx[k].push_back(data_out[k*PW +: PW]);
          rx_occ[k] = rx_occ[k] + 1;
        end else if (acc && err_m[k] < 255) begin
          err_m[k] = err_m[k] + 1;
        end
        rx_occ[k] = rx_occ[k] - int'(prx);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every head consumed by the mesh or the RX consumer is compared in order.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NT; k++) begin
        if (pndng_i_in[k] && popin[k]) begin
          if (exp_tx[k].size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected ch%0d got=%h expected=none", k, data_out_i_in[k*PW +: PW]);
          end else begin
            chk("tx_head", k, data_out_i_in[k*PW +: PW], exp_tx[k].pop_front());
          end
        end
        if (rx_valid[k] && rx_pop[k]) begin
          if (exp_rx[k].size() == 0) begin
            checks++; failures++;
            $display("FAIL rx_unexpected ch%0d got=%h expected=none", k, rx_data[k*PW +: PW]);
          end else begin
            chk("rx_head", k, rx_data[k*PW +: PW], exp_rx[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    clr();
    tx_row = '0; tx_col = '0; tx_mode = '0; tx_payload = '0; data_out = '0;
    own_row = NT*4'($urandom);
    own_col = NT*4'($urandom);
    for (int k = 0; k < NT; k++) begin
      own_row[k*4 +: 4] = 4'($urandom_range(0, 14));
      own_col[k*4 +: 4] = 4'($urandom);
      tx_occ[k] = 0; rx_occ[k] = 0; err_m[k] = 0;
    end
    own_row[12 +: 4] = 4'd0;
    own_col[12 +: 4] = 4'd1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state; mesh offers packets during reset and must not be popped.
    pndng = '1;
    for (int k = 0; k < NT; k++) set_rx(k, 4'hF, 4'hF, PLW'(k));
    tick();
    reset = 1'b0;
    clr();
    for (int k = 0; k < NT; k++) begin
      chk("rst_data_out_i_in", k, data_out_i_in[k*PW +: PW], '0);
      chk("rst_rx_data",       k, rx_data[k*PW +: PW],       '0);
    end

    // ch0 single packet, then popped.
    set_tx(0, 4'h1, 4'h0, 1'b1, PLW'(5));
    tick();
    clr();
    chk("ch0_head_fmt", 0, data_out_i_in[0 +: PW], 32'h0010_8005);
    popin[0] = 1'b1;
    tick();
    clr();
    chk("ch0_empty_after_pop", 0, PW'(pndng_i_in[0]), '0);

    // ch2 overflow: fifth push dropped, four drained in order.
    for (int i = 0; i < 5; i++) begin
      set_tx(2, 4'(i), 4'(i + 1), 1'(i), PLW'(100 + i));
      tick();
      clr();
    end
    chk("ch2_full", 2, PW'(tx_full[2]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      popin[2] = 1'b1;
      tick();
    end
    clr();
    chk("ch2_drained", 2, PW'(exp_tx[2].size()), '0);

    // ch1 full with push+pop, then empty with push+pop.
    for (int i = 0; i < 4; i++) begin
      set_tx(1, 4'h3, 4'h2, 1'b0, PLW'(200 + i));
      tick();
      clr();
    end
    set_tx(1, 4'h7, 4'h6, 1'b1, PLW'(299));
    popin[1] = 1'b1;
    tick();
    clr();
    chk("ch1_still_full", 1, PW'(tx_full[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      popin[1] = 1'b1;
      tick();
    end
    clr();
    set_tx(1, 4'h5, 4'h5, 1'b0, PLW'(333));
    popin[1] = 1'b1;
    tick();
    clr();
    chk("ch1_push_pop_empty", 1, PW'(pndng_i_in[1]), 32'd1);
    popin[1] = 1'b1;
    tick();
    clr();

    // ch3 address filter: own, broadcast, foreign.
    set_rx(3, 4'h0, 4'h1, PLW'(11)); tick();
    set_rx(3, 4'hF, 4'hF, PLW'(12)); tick();
    set_rx(3, 4'h1, 4'h1, PLW'(13)); tick();
    clr();
    chk("ch3_err_one", 3, PW'(err_cnt[3*8 +: 8]), 32'd1);
    for (int i = 0; i < 300; i++) begin
      set_rx(3, 4'h2, 4'h2, PLW'(i));
      tick();
    end
    clr();
    chk("ch3_err_sat", 3, PW'(err_cnt[3*8 +: 8]), 32'hFF);

    // ch3 RX full: no pop even with a same-cycle rx_pop; pop resumes next cycle.
    set_rx(3, 4'h0, 4'h1, PLW'(21)); tick();
    set_rx(3, 4'hF, 4'hF, PLW'(22)); tick();
    set_rx(3, 4'h0, 4'h1, PLW'(23));
    #1;
    chk("ch3_full_no_pop", 3, PW'(pop[3]), '0);
    tick();
    rx_pop[3] = 1'b1;
    tick();
    rx_pop[3] = 1'b0;
    #1;
    chk("ch3_pop_after_rx_pop", 3, PW'(pop[3]), 32'd1);
    tick();
    clr();
    for (int i = 0; i < 5; i++) begin
      rx_pop[3] = 1'b1;
      tick();
    end
    clr();

    // Randomized traffic on all channels.
    for (int n = 0; n < 400; n++) begin
      clr();
      for (int k = 0; k < NT; k++) begin
        if ($urandom_range(0, 1) == 1)
          set_tx(k, 4'($urandom), 4'($urandom), 1'($urandom), PLW'($urandom));
        popin[k]  = 1'($urandom);
        rx_pop[k] = 1'($urandom);
        if ($urandom_range(0, 1) == 1) rnd_rx(k);
      end
      tick();
    end
    clr();
    popin = '1;
    rx_pop = '1;
    repeat (6) tick();
    clr();
    for (int k = 0; k < NT; k++) begin
      chk("tx_drained", k, PW'(exp_tx[k].size()), '0);
      chk("rx_drained", k, PW'(exp_rx[k].size()), '0);
    end

    // Three entries in every FIFO plus an error each, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NT; k++) begin
        set_tx(k, 4'(i), 4'(k), 1'b0, PLW'(i));
        set_rx(k, 4'hF, 4'hF, PLW'(i));
      end
      tick();
    end
    clr();
    for (int k = 0; k < NT; k++) set_rx(k, 4'hF, 4'hE, PLW'(k));
    tick();
    clr();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < NT; k++) begin
      chk("rst2_pndng_i_in", k, PW'(pndng_i_in[k]), '0);
      chk("rst2_rx_valid",   k, PW'(rx_valid[k]),   '0);
      chk("rst2_err_cnt",    k, PW'(err_cnt[k*8 +: 8]), '0);
      chk("rst2_data",       k, data_out_i_in[k*PW +: PW] | rx_data[k*PW +: PW], '0);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
